// File: rtl/v810_ext_pkg.sv
// Shared types and constants for the V810 external-memory responder.
package v810_ext_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } ext_state_t;

   // Byte-enable codes (active low) that map onto the low half of a 16-bit device
   localparam logic [3:0] BEN_LO_B0 = 4'b1110;
   localparam logic [3:0] BEN_LO_B1 = 4'b1101;
   localparam logic [3:0] BEN_LO_H  = 4'b1100;
   localparam logic [3:0] BEN_LO_W  = 4'b0000;

   function automatic logic is_lo_half(input logic [3:0] ben);
      return (ben == BEN_LO_B0) || (ben == BEN_LO_B1) ||
             (ben == BEN_LO_H)  || (ben == BEN_LO_W);
   endfunction

endpackage

// File: rtl/v810_ext_lane_steer.sv
// Data/byte-enable lane steering between the CPU bus and a 32-bit memory,
// for either a 32-bit device or a 16-bit device hung on the low CPU lanes.
module v810_ext_lane_steer
   import v810_ext_pkg::*;
(
   input  logic        dw16,
   input  logic [3:0]  ben,
   input  logic [31:0] d_o,
   input  logic [31:0] mem_do,
   output logic [31:0] mem_di,
   output logic [31:0] d_i,
   output logic [3:0]  mem_ben
);

   // Pass-through for 32-bit devices; 16-bit devices pick a memory half from BEn
   always_comb begin
      mem_di  = d_o;
      d_i     = mem_do;
      mem_ben = ben;
      if (dw16) begin
         if (is_lo_half(ben)) begin
            mem_di = {16'h0000, d_o[15:0]};
            d_i    = {16'h0000, mem_do[15:0]};
         end else begin
            mem_di = {d_o[15:0], 16'h0000};
            d_i    = {16'h0000, mem_do[31:16]};
         end
      end
   end

endmodule

// File: rtl/v810_ext_mem_port.sv
// V810 external-bus memory responder: programmable read/write wait states,
// 16/32-bit device width, chip-select gating and abort on strobe release.
module v810_ext_mem_port
   import v810_ext_pkg::*;
#(
   parameter int AW  = 10,
   parameter int WSW = 4
) (
   input  logic           CLK,
   input  logic           RESn,
   input  logic           CE,
   input  logic [31:0]    A,
   input  logic [31:0]    D_O,
   output logic [31:0]    D_I,
   input  logic [3:0]     BEn,
   input  logic           DAn,
   input  logic           MRQn,
   input  logic           RW,
   input  logic           SEL,
   output logic           READYn,
   output logic           SZRQn,
   input  logic [WSW-1:0] CFG_WS_RD,
   input  logic [WSW-1:0] CFG_WS_WR,
   input  logic           CFG_DW16,
   output logic [AW-1:0]  MEM_A,
   output logic [31:0]    MEM_DI,
   input  logic [31:0]    MEM_DO,
   output logic [3:0]     MEM_BEn,
   output logic           MEM_CEn,
   output logic           MEM_WEn,
   output logic           BUSY
);

   ext_state_t     state_q, state_d;
   logic [WSW-1:0] cnt_q, cnt_d;
   logic           dw16_q, dw16_d;

   logic           access;
   logic [WSW-1:0] ws;
   logic           ready;
   logic           dw16_eff;
   logic           unused_a_bits;

   assign access   = ~DAn & SEL;
   assign ws       = RW ? CFG_WS_RD : CFG_WS_WR;
   assign ready    = (state_q == IDLE) ? (ws == '0) : (cnt_q == '0);
   assign dw16_eff = (state_q == IDLE) ? CFG_DW16 : dw16_q;

   // State, wait counter and latched device width; reset drops straight to IDLE
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dw16_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dw16_q  <= dw16_d;
      end
   end

   // Next state: CE gates every advance; in WAIT, a dropped access aborts
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dw16_d  = dw16_q;
      if (CE) begin
         case (state_q)
            IDLE: begin
               if (access && (ws != '0)) begin
                  state_d = WAIT;
                  cnt_d   = ws - WSW'(1);
                  dw16_d  = CFG_DW16;
               end
            end
            WAIT: begin
               if (!access || ready) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - WSW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign READYn  = ~(access & ready & RESn);
   assign SZRQn   = ~(access & ready & dw16_eff & RESn);
   assign MEM_WEn = ~(access & ready & ~RW & CE & RESn);
   assign MEM_CEn = MRQn | ~SEL;
   assign BUSY    = (state_q == WAIT);
   assign MEM_A   = A[AW+1:2];

   assign unused_a_bits = ^{A[31:AW+2], A[1:0]};

   v810_ext_lane_steer u_lane_steer (
      .dw16    (dw16_eff),
      .ben     (BEn),
      .d_o     (D_O),
      .mem_do  (MEM_DO),
      .mem_di  (MEM_DI),
      .d_i     (D_I),
      .mem_ben (MEM_BEn)
   );

endmodule

// File: tb/tb_v810_ext_mem_port.sv
// Directed bench for v810_ext_mem_port with a small byte-enabled memory model.
module tb_v810_ext_mem_port;

   localparam int AW  = 10;
   localparam int WSW = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           ce;
   logic [31:0]    a;
   logic [31:0]    d_o;
   logic [31:0]    d_i;
   logic [3:0]     ben;
   logic           dan;
   logic           mrqn;
   logic           rw;
   logic           sel;
   logic           readyn;
   logic           szrqn;
   logic [WSW-1:0] ws_rd;
   logic [WSW-1:0] ws_wr;
   logic           cfg_dw16;
   logic [AW-1:0]  mem_a;
   logic [31:0]    mem_di;
   logic [31:0]    mem_do;
   logic [3:0]     mem_ben;
   logic           mem_cen;
   logic           mem_wen;
   logic           busy;

   logic [31:0]    mem [0:(1<<AW)-1];
   int             wr_count = 0;
   int             checks   = 0;
   int             failures = 0;
   int             base;

   always #5 clk = ~clk;

   v810_ext_mem_port #(.AW(AW), .WSW(WSW)) dut (
      .CLK       (clk),
      .RESn      (rst_n),
      .CE        (ce),
      .A         (a),
      .D_O       (d_o),
      .D_I       (d_i),
      .BEn       (ben),
      .DAn       (dan),
      .MRQn      (mrqn),
      .RW        (rw),
      .SEL       (sel),
      .READYn    (readyn),
      .SZRQn     (szrqn),
      .CFG_WS_RD (ws_rd),
      .CFG_WS_WR (ws_wr),
      .CFG_DW16  (cfg_dw16),
      .MEM_A     (mem_a),
      .MEM_DI    (mem_di),
      .MEM_DO    (mem_do),
      .MEM_BEn   (mem_ben),
      .MEM_CEn   (mem_cen),
      .MEM_WEn   (mem_wen),
      .BUSY      (busy)
   );

   // Asynchronous-read memory
   assign mem_do = mem[mem_a];

   // Synchronous byte-enabled write, counting every write strobe taken
   always @(posedge clk) begin
      if (!mem_wen && !mem_cen) begin
         for (int b = 0; b < 4; b++) begin
            if (!mem_ben[b]) mem[mem_a][8*b +: 8] <= mem_di[8*b +: 8];
         end
         wr_count <= wr_count + 1;
      end
   end

   task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task applyStimulus(input logic rw_i, input logic [31:0] a_i, input logic [31:0] d_i_v,
                      input logic [3:0] ben_i, input logic dan_i);
      rw   = rw_i;
      a    = a_i;
      d_o  = d_i_v;
      ben  = ben_i;
      dan  = dan_i;
      mrqn = dan_i;
   endtask

   task nextCycle;
      @(posedge clk);
      #1;
   endtask

   task midCycle;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
      mem[1] = 32'hDEADBEEF;
      mem[3] = 32'hAAAA5555;

      rst_n = 1'b0; ce = 1'b1; sel = 1'b1; cfg_dw16 = 1'b0;
      ws_rd = '0; ws_wr = '0;
      applyStimulus(1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
      #2;
      checkOutput("rst_readyn", readyn, 1);
      checkOutput("rst_szrqn", szrqn, 1);
      checkOutput("rst_wen", mem_wen, 1);
      checkOutput("rst_busy", busy, 0);
      nextCycle;
      rst_n = 1'b1;

      // 32-bit, zero wait-state read
      applyStimulus(1'b1, 32'h4, 32'h0, 4'h0, 1'b0);
      midCycle;
      checkOutput("ws0_readyn", readyn, 0);
      checkOutput("ws0_d_i", d_i, 32'hDEADBEEF);
      checkOutput("ws0_szrqn", szrqn, 1);
      checkOutput("ws0_busy", busy, 0);
      nextCycle;

      // Deselected write: no ready, no strobe, memory disabled
      sel = 1'b0;
      applyStimulus(1'b0, 32'h8, 32'h99, 4'h0, 1'b0);
      midCycle;
      checkOutput("sel0_readyn", readyn, 1);
      checkOutput("sel0_wen", mem_wen, 1);
      checkOutput("sel0_cen", mem_cen, 1);
      nextCycle;
      sel = 1'b1;
      applyStimulus(1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
      midCycle;
      checkOutput("sel0_no_write", wr_count, 0);
      nextCycle;

      // 32-bit write with three wait states
      ws_wr = 4'd3;
      base  = wr_count;
      applyStimulus(1'b0, 32'h8, 32'h12345678, 4'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         midCycle;
         checkOutput($sformatf("ws3_readyn_%0d", i), readyn, (i == 3) ? 0 : 1);
         checkOutput($sformatf("ws3_wen_%0d", i), mem_wen, (i == 3) ? 0 : 1);
         checkOutput($sformatf("ws3_busy_%0d", i), busy, (i >= 1) ? 1 : 0);
         nextCycle;
      end
      applyStimulus(1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
      midCycle;
      checkOutput("ws3_mem", mem[2], 32'h12345678);
      checkOutput("ws3_once", wr_count - base, 1);
      nextCycle;

      // 16-bit device, one wait state, word split into two bus cycles
      cfg_dw16 = 1'b1;
      ws_rd    = 4'd1;
      applyStimulus(1'b1, 32'hC, 32'h0, 4'b0000, 1'b0);
      midCycle;
      checkOutput("h16_lo_wait", readyn, 1);
      nextCycle;
      midCycle;
      checkOutput("h16_lo_readyn", readyn, 0);
      checkOutput("h16_lo_szrqn", szrqn, 0);
      checkOutput("h16_lo_d_i", d_i, 32'h00005555);
      nextCycle;
      ben = 4'b0011;
      midCycle;
      checkOutput("h16_hi_wait", readyn, 1);
      nextCycle;
      midCycle;
      checkOutput("h16_hi_readyn", readyn, 0);
      checkOutput("h16_hi_szrqn", szrqn, 0);
      checkOutput("h16_hi_d_i", d_i, 32'h0000AAAA);
      nextCycle;
      applyStimulus(1'b1, 32'h0, 32'h0, 4'hF, 1'b1);

      // 16-bit high-halfword write, zero wait states
      ws_wr = 4'd0;
      applyStimulus(1'b0, 32'h10, 32'h0000BEEF, 4'b0011, 1'b0);
      midCycle;
      checkOutput("hw_mem_di", mem_di, 32'hBEEF0000);
      checkOutput("hw_mem_ben", mem_ben, 4'b0011);
      checkOutput("hw_wen", mem_wen, 0);
      checkOutput("hw_szrqn", szrqn, 0);
      nextCycle;
      applyStimulus(1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
      midCycle;
      checkOutput("hw_mem", mem[4], 32'hBEEF0000);
      nextCycle;

      // Abort: ws_rd=5, strobe released after two cycles
      cfg_dw16 = 1'b0;
      ws_rd    = 4'd5;
      applyStimulus(1'b1, 32'h4, 32'h0, 4'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         midCycle;
         checkOutput($sformatf("abort_readyn_%0d", i), readyn, 1);
         checkOutput($sformatf("abort_busy_%0d", i), busy, (i == 1) ? 1 : 0);
         checkOutput($sformatf("abort_wen_%0d", i), mem_wen, 1);
         nextCycle;
      end
      applyStimulus(1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
      midCycle;
      checkOutput("abort_rel_busy", busy, 1);
      checkOutput("abort_rel_readyn", readyn, 1);
      nextCycle;
      midCycle;
      checkOutput("abort_idle_busy", busy, 0);
      nextCycle;

      // CE low for three cycles mid-WAIT stretches a 3-cycle read to 6
      ws_rd = 4'd2;
      applyStimulus(1'b1, 32'h4, 32'h0, 4'h0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         ce = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
         midCycle;
         checkOutput($sformatf("ce_readyn_%0d", i), readyn, (i == 5) ? 0 : 1);
         checkOutput($sformatf("ce_busy_%0d", i), busy, (i >= 1) ? 1 : 0);
         nextCycle;
      end
      ce = 1'b1;
      applyStimulus(1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
      nextCycle;

      // Reset pulse during WAIT with cnt=2, then a clean new write
      ws_wr = 4'd4;
      base  = wr_count;
      applyStimulus(1'b0, 32'h18, 32'h11111111, 4'h0, 1'b0);
      nextCycle;
      nextCycle;
      #1;
      checkOutput("rst_mid_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_readyn", readyn, 1);
      checkOutput("rst_mid_szrqn", szrqn, 1);
      checkOutput("rst_mid_wen", mem_wen, 1);
      applyStimulus(1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
      rst_n = 1'b1;
      nextCycle;
      ws_wr = 4'd1;
      applyStimulus(1'b0, 32'h14, 32'hCAFEF00D, 4'h0, 1'b0);
      midCycle;
      checkOutput("post_rst_wait", readyn, 1);
      checkOutput("post_rst_busy", busy, 0);
      nextCycle;
      midCycle;
      checkOutput("post_rst_readyn", readyn, 0);
      checkOutput("post_rst_wen", mem_wen, 0);
      nextCycle;
      applyStimulus(1'b1, 32'h0, 32'h0, 4'hF, 1'b1);
      midCycle;
      checkOutput("post_rst_mem", mem[5], 32'hCAFEF00D);
      checkOutput("aborted_mem", mem[6], 32'h0);
      checkOutput("post_rst_writes", wr_count - base, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
